uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter G_BAUD_DIV, default 16: clocks per serial bit; legal range 2..65535.
REQ-002 SHALL have parameter G_FIFO_DEPTH, default 16: FIFO entries; power of 2, legal range 2..256.
REQ-003 SHALL have parameter G_NSTOP, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have port i_clk, input, 1 bit: processor clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port i_wr, input, 1 bit: single-cycle outport write strobe from the 9x8 core.
REQ-007 SHALL have port i_data, input, 8 bits: outport data, sampled when i_wr=1.
REQ-008 SHALL have port o_full, output, 1 bit: FIFO holds G_FIFO_DEPTH entries; registered.
REQ-009 SHALL have port o_busy, output, 1 bit: FIFO non-empty or frame in progress; read by the core through an inport.
REQ-010 SHALL have port o_overflow, output, 1 bit: sticky flag set by a dropped write.
REQ-011 SHALL have port i_clr_overflow, input, 1 bit: single-cycle strobe that clears o_overflow.
REQ-012 SHALL have port o_uart_tx, output, 1 bit: serial line, idle high; driven by a flop.

Function
REQ-013 SHALL store each byte from a cycle with i_wr=1 and o_full=0 at the FIFO write pointer, then advance the pointer modulo G_FIFO_DEPTH.
REQ-014 SHALL drop a write when o_full=1 in that cycle, even if a pop occurs in the same cycle, and SHALL set o_overflow on the next edge.
REQ-015 SHALL give i_clr_overflow priority over a same-cycle dropped write, so o_overflow is 0 afterwards.
REQ-016 SHALL use pointers one bit wider than log2(G_FIFO_DEPTH): empty when the pointers are equal, full when only the MSBs differ.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop the head byte into the shift register, drive o_uart_tx=0 and enter START, all on one edge.
REQ-019 SHALL hold every bit for exactly G_BAUD_DIV clocks, using a divisor counter reloaded to G_BAUD_DIV-1 at each bit start.
REQ-020 SHALL, after START, shift out 8 data bits LSB first in DATA, then drive G_NSTOP high bits in STOP.
REQ-021 SHALL take exactly (9+G_NSTOP)*G_BAUD_DIV clocks per frame.
REQ-022 SHALL, at the end of the last stop bit with the FIFO non-empty, pop the next byte and go straight to START with no idle gap; otherwise it SHALL go to IDLE.
REQ-023 SHALL produce its first start-bit low on the second rising edge after the edge that samples i_wr, when idle and empty.
REQ-024 SHALL allow a simultaneous write and pop in a non-full FIFO, leaving the count unchanged.
REQ-025 SHALL drive o_busy=1 from the edge after an accepted write until the end of the final stop bit.
REQ-026 SHALL update o_full on the edge that changes the count, with no combinational path from i_wr.

Reset
REQ-027 SHALL, on an edge with i_rst=1, set the FIFO pointers to 0, state to IDLE, divisor counter to 0, o_uart_tx=1, o_full=0, o_busy=0 and o_overflow=0.
REQ-028 SHALL, when reset is asserted mid-frame, abort the frame and discard FIFO contents; o_uart_tx SHALL be 1 on the next edge.
REQ-029 SHALL ignore i_wr and i_clr_overflow while i_rst=1.

Verification
REQ-030 SHALL verify: G_BAUD_DIV=4, G_NSTOP=1, write 0xA5 -> o_uart_tx =0,1,0,1,0,0,1,0,1,1, each held 4 clocks, 40 clocks total, o_busy=0 afterwards.
REQ-031 SHALL verify: back-to-back writes of 0x00 then 0xFF -> two contiguous 40-clock frames with no high gap between them.
REQ-032 SHALL verify: G_FIFO_DEPTH=4, 6 writes while a frame is in progress -> o_full=1 after the 4th accepted write, 2 writes dropped, o_overflow=1, only the accepted bytes sent, in order.
REQ-033 SHALL verify: i_clr_overflow asserted in the same cycle as a dropped write -> o_overflow=0.
REQ-034 SHALL verify: i_rst asserted during data bit 3 -> o_uart_tx=1 on the next edge, o_busy=0, and the next write produces a clean frame.
REQ-035 SHALL verify: G_NSTOP=2, write 0x3C -> frame of 44 clocks ending with 8 high clocks.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1/8N2 UART transmitter.
// The core writes bytes through an outport strobe; the transmitter drains
// the FIFO back-to-back with no idle gap between queued frames.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for the FIFO to become non-empty
// START | start bit (low) for G_BAUD_DIV clocks
// DATA  | 8 data bits, LSB first, each held G_BAUD_DIV clocks
// STOP  | G_NSTOP stop bits (high); pops the next byte at the end if any
module uart_tx_fifo #(
  parameter int G_BAUD_DIV   = 16,
  parameter int G_FIFO_DEPTH = 16,
  parameter int G_NSTOP      = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_overflow,
  input  logic       i_clr_overflow,
  output logic       o_uart_tx
);

  localparam int AW = $clog2(G_FIFO_DEPTH);
  localparam logic [AW:0] PTR_FULL_XOR = {1'b1, {AW{1'b0}}};
  localparam logic [15:0] DIV_RELOAD = 16'(G_BAUD_DIV - 1);
  localparam logic STOP_LAST = 1'(G_NSTOP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]  mem [G_FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr_nxt;
  logic [AW:0] rd_ptr_nxt;
  logic        empty;
  logic        push;
  logic        pop;
  logic [7:0]  head;

  state_t      state;
  logic [15:0] div_cnt;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;
  logic [7:0]  shreg;

  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign push = i_wr && !o_full;

  // Pop whenever the transmitter is ready to load a new byte.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state == S_IDLE)
        pop = 1'b1;
      else if (state == S_STOP && div_cnt == 16'd0 && stop_cnt == STOP_LAST)
        pop = 1'b1;
    end
  end

  // Next pointer values, shared by the pointer and full-flag registers.
  always_comb begin
    wr_ptr_nxt = push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + 1'b1 : rd_ptr;
  end

  // FIFO storage; contents are don't-care after reset since the pointers clear.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst)
      mem[wr_ptr[AW-1:0]] <= i_data;
  end

  // Pointers and registered full flag (full when only the MSBs differ).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_full <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      o_full <= ((wr_ptr_nxt ^ rd_ptr_nxt) == PTR_FULL_XOR);
    end
  end

  // Sticky overflow; a clear strobe wins over a same-cycle dropped write.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_overflow <= 1'b0;
    else if (i_clr_overflow)
      o_overflow <= 1'b0;
    else if (i_wr && o_full)
      o_overflow <= 1'b1;
  end

  // Transmit FSM: bit timing from a down-counter reloaded at every bit start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      div_cnt   <= 16'd0;
      bit_cnt   <= 3'd0;
      stop_cnt  <= 1'b0;
      shreg     <= 8'd0;
      o_uart_tx <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          o_uart_tx <= 1'b1;
          if (!empty) begin
            shreg     <= head;
            o_uart_tx <= 1'b0;
            div_cnt   <= DIV_RELOAD;
            state     <= S_START;
          end
        end
        S_START: begin
          if (div_cnt == 16'd0) begin
            o_uart_tx <= shreg[0];
            shreg     <= {1'b0, shreg[7:1]};
            bit_cnt   <= 3'd0;
            div_cnt   <= DIV_RELOAD;
            state     <= S_DATA;
          end else begin
            div_cnt <= div_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (div_cnt == 16'd0) begin
            div_cnt <= DIV_RELOAD;
            if (bit_cnt == 3'd7) begin
              o_uart_tx <= 1'b1;
              stop_cnt  <= 1'b0;
              state     <= S_STOP;
            end else begin
              o_uart_tx <= shreg[0];
              shreg     <= {1'b0, shreg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (div_cnt == 16'd0) begin
            if (stop_cnt == STOP_LAST) begin
              if (!empty) begin
                shreg     <= head;
                o_uart_tx <= 1'b0;
                div_cnt   <= DIV_RELOAD;
                state     <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
              div_cnt  <= DIV_RELOAD;
            end
          end else begin
            div_cnt <= div_cnt - 16'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          o_uart_tx <= 1'b1;
        end
      endcase
    end
  end

  // Busy covers both queued bytes and a frame on the wire; all terms are flops.
  assign o_busy = !empty || (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed table-driven bench for uart_tx_fifo.
// dut1: 4 clocks/bit, 4-entry FIFO, 1 stop bit. dut2: same with 2 stop bits.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr1, clr1, wr2, clr2;
  logic [7:0] data1, data2;
  logic       full1, busy1, ovf1, tx1;
  logic       full2, busy2, ovf2, tx2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;   // line levels in transmit order, seq[0] first
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_tx_fifo #(.G_BAUD_DIV(4), .G_FIFO_DEPTH(4), .G_NSTOP(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_wr(wr1), .i_data(data1),
    .o_full(full1), .o_busy(busy1), .o_overflow(ovf1),
    .i_clr_overflow(clr1), .o_uart_tx(tx1)
  );

  uart_tx_fifo #(.G_BAUD_DIV(4), .G_FIFO_DEPTH(4), .G_NSTOP(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_wr(wr2), .i_data(data2),
    .o_full(full2), .o_busy(busy2), .o_overflow(ovf2),
    .i_clr_overflow(clr2), .o_uart_tx(tx2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic tx_of(input int which);
    return (which == 1) ? tx1 : tx2;
  endfunction

  function automatic logic busy_of(input int which);
    return (which == 1) ? busy1 : busy2;
  endfunction

  // Write one byte into an idle, empty DUT and check the whole frame clock by clock.
  task automatic send_frame(input int which, input logic [7:0] b,
                            input logic [10:0] seq, input int nbits);
    int n;
    n = nbits * 4;
    if (which == 1) begin wr1 = 1'b1; data1 = b; end
    else            begin wr2 = 1'b1; data2 = b; end
    tick();
    wr1 = 1'b0;
    wr2 = 1'b0;
    check($sformatf("tx_high_after_wr_edge %h", b), tx_of(which), 1'b1);
    check($sformatf("busy_after_wr %h", b), busy_of(which), 1'b1);
    tick();
    for (int k = 0; k < n; k++) begin
      check($sformatf("frame %h clk %0d", b, k), tx_of(which), seq[k/4]);
      tick();
    end
    check($sformatf("idle_tx_after %h", b), tx_of(which), 1'b1);
    check($sformatf("idle_busy_after %h", b), busy_of(which), 1'b0);
  endtask

  initial begin
    logic [7:0] bytes5 [5];
    vecs[0] = '{data: 8'hA5, seq: 10'b1101001010};
    vecs[1] = '{data: 8'h00, seq: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, seq: 10'b1111111110};
    vecs[3] = '{data: 8'h3C, seq: 10'b1001111000};
    vecs[4] = '{data: 8'h01, seq: 10'b1000000010};
    vecs[5] = '{data: 8'h80, seq: 10'b1100000000};

    rst = 1'b1; wr1 = 1'b0; clr1 = 1'b0; wr2 = 1'b0; clr2 = 1'b0;
    data1 = 8'h00; data2 = 8'h00;
    tick();
    tick();
    check("reset_tx", tx1, 1'b1);
    check("reset_busy", busy1, 1'b0);
    check("reset_full", full1, 1'b0);
    check("reset_ovf", ovf1, 1'b0);
    rst = 1'b0;
    tick();

    // single frames from the table
    for (int i = 0; i < 6; i++)
      send_frame(1, vecs[i].data, {1'b1, vecs[i].seq}, 10);

    // back-to-back 0x00 then 0xFF: 80 contiguous clocks
    wr1 = 1'b1; data1 = 8'h00;
    tick();
    data1 = 8'hFF;
    tick();
    wr1 = 1'b0;
    for (int k = 0; k < 80; k++) begin
      check($sformatf("b2b clk %0d", k), tx1,
            (k < 40) ? vecs[1].seq[k/4] : vecs[2].seq[(k-40)/4]);
      tick();
    end
    check("b2b_idle_busy", busy1, 1'b0);

    // overflow: 0x11 starts a frame, then six writes 0x21..0x26 while it runs
    bytes5[0] = 8'h11; bytes5[1] = 8'h21; bytes5[2] = 8'h22;
    bytes5[3] = 8'h23; bytes5[4] = 8'h24;
    wr1 = 1'b1; data1 = 8'h11;
    tick();
    data1 = 8'h21;
    tick();
    for (int k = 0; k < 200; k++) begin
      check($sformatf("ovf_frames clk %0d", k), tx1, frame_of(bytes5[k/40])[(k%40)/4]);
      if (k < 6) begin
        check($sformatf("ovf_full after wr %0d", k + 1), full1, (k >= 3));
        check($sformatf("ovf_flag after wr %0d", k + 1), ovf1, (k >= 4));
      end
      if (k < 5) begin wr1 = 1'b1; data1 = 8'h22 + 8'(k); end
      else wr1 = 1'b0;
      tick();
    end
    check("ovf_drain_busy", busy1, 1'b0);
    check("ovf_drain_full", full1, 1'b0);
    check("ovf_sticky", ovf1, 1'b1);

    // clear strobe beats a same-cycle dropped write
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    check("clr_alone", ovf1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wr1 = 1'b1; data1 = 8'h40 + 8'(i);
      tick();
    end
    check("refill_full", full1, 1'b1);
    check("refill_ovf", ovf1, 1'b0);
    clr1 = 1'b1;
    tick();
    clr1 = 1'b0;
    check("clr_vs_drop_ovf", ovf1, 1'b0);
    check("clr_vs_drop_full", full1, 1'b1);
    tick();
    check("drop_sets_ovf", ovf1, 1'b1);

    // reset mid-frame with a write pending: everything clears, write ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr1 = 1'b0;
    check("rst_ovf", ovf1, 1'b0);
    check("rst_full", full1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_tx", tx1, 1'b1);
    tick();
    check("rst_wr_ignored", busy1, 1'b0);

    // reset during data bit 3 of 0xA5
    wr1 = 1'b1; data1 = 8'hA5;
    tick();
    wr1 = 1'b0;
    tick();
    for (int k = 0; k < 18; k++) begin
      check($sformatf("pre_rst clk %0d", k), tx1, vecs[0].seq[k/4]);
      if (k < 17) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midframe_rst_tx", tx1, 1'b1);
    check("midframe_rst_busy", busy1, 1'b0);
    tick();
    check("midframe_rst_stays_idle", tx1, 1'b1);
    send_frame(1, vecs[3].data, {1'b1, vecs[3].seq}, 10);

    // two stop bits: 44 clocks, last 8 high
    send_frame(2, vecs[3].data, {1'b1, vecs[3].seq}, 11);
    check("nstop2_full", full2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
